// File: rtl/cam_param_pkg.sv
// Constants and FSM state encoding for the camera parameter store.
// These constants are shared with the parameter store.
package cam_param_pkg;

  localparam logic [7:0] CAM_PARAM_SYNC      = 8'hA5;
  localparam int         CAM_PARAM_FRAME_LEN = 7;
  localparam int         CAM_PARAM_ADDR_W    = 3;
  localparam int         CAM_PARAM_DATA_W    = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_D3,
    ST_D2,
    ST_D1,
    ST_D0,
    ST_CSUM,
    ST_COMMIT,
    ST_ERROR
  } cam_param_state_e;

endpackage

// File: rtl/cam_param_loader.sv
// Parses 7-byte SYNC/ADDR/D3..D0/CSUM frames into one-cycle parameter writes; wr_en the cycle after CSUM.
// rx_ready drops only in COMMIT/ERROR. Define CAM_PARAM_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES.
module cam_param_loader
  import cam_param_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = CAM_PARAM_SYNC,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [CAM_PARAM_ADDR_W-1:0] param_addr,
  output logic [CAM_PARAM_DATA_W-1:0] param_data,
  output logic                        wr_en,
  output logic                        frame_ok,
  output logic                        frame_err,
  output logic                        busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  cam_param_state_e state, state_nxt;

  logic        accept;
  logic        csum_good;
  logic        to_hit;
  logic [7:0]  addr_q;
  logic [7:0]  sum_q;
  logic [31:0] shift_q;

  assign rx_ready  = (state != ST_COMMIT) && (state != ST_ERROR);
  assign busy      = (state != ST_IDLE);
  assign accept    = rx_valid && rx_ready;
  assign csum_good = (rx_data == sum_q) && (addr_q[7:3] == 5'd0);

`ifdef CAM_PARAM_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state == ST_ADDR) || (state == ST_D3) || (state == ST_D2) ||
                    (state == ST_D1)   || (state == ST_D0) || (state == ST_CSUM);
  // An accepted byte always beats an expiring count.
  assign to_hit   = in_frame && !accept && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (!in_frame || accept) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && (rx_data == SYNC_BYTE)) state_nxt = ST_ADDR;
      ST_ADDR:   if (accept) state_nxt = ST_D3; else if (to_hit) state_nxt = ST_ERROR;
      ST_D3:     if (accept) state_nxt = ST_D2; else if (to_hit) state_nxt = ST_ERROR;
      ST_D2:     if (accept) state_nxt = ST_D1; else if (to_hit) state_nxt = ST_ERROR;
      ST_D1:     if (accept) state_nxt = ST_D0; else if (to_hit) state_nxt = ST_ERROR;
      ST_D0:     if (accept) state_nxt = ST_CSUM; else if (to_hit) state_nxt = ST_ERROR;
      ST_CSUM: begin
        if (accept) begin
          state_nxt = csum_good ? ST_COMMIT : ST_ERROR;
        end else if (to_hit) begin
          state_nxt = ST_ERROR;
        end
      end
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_ERROR:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Sync bytes inside a frame are plain data; the sum covers ADDR..D0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      sum_q   <= '0;
      shift_q <= '0;
    end else if (accept) begin
      case (state)
        ST_ADDR: begin
          addr_q <= rx_data;
          sum_q  <= rx_data;
        end
        ST_D3, ST_D2, ST_D1, ST_D0: begin
          shift_q <= {shift_q[23:0], rx_data};
          sum_q   <= sum_q + rx_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      param_addr <= '0;
      param_data <= '0;
    end else begin
      wr_en     <= (state_nxt == ST_COMMIT);
      frame_ok  <= (state_nxt == ST_COMMIT);
      frame_err <= (state_nxt == ST_ERROR);
      if (state_nxt == ST_COMMIT) begin
        param_addr <= addr_q[2:0];
        param_data <= shift_q;
      end
    end
  end

endmodule

// File: doc/cam_param_loader.md
Name: cam_param_loader

Overview:
- Writer side of the camera parameter store's write port.
- Parses a framed byte stream from the host link (UART/bridge, valid/ready) into single-cycle parameter writes: wr_en, param_addr[2:0], param_data[31:0].
- Sits between the host byte receiver and the camera parameter store.
- Validates framing, address range and checksum; reports per-frame success or error.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with the optional feature); must be ≥2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader accepts byte this cycle
- param_addr  out  3  parameter index for write
- param_data  out  32  parameter value for write
- wr_en  out  1  one-cycle write strobe to the parameter store
- frame_ok  out  1  one-cycle pulse: frame committed
- frame_err  out  1  one-cycle pulse: frame rejected
- busy  out  1  high when FSM not in IDLE

Behaviour:
- Byte accepted iff rx_valid && rx_ready on a rising clk edge.
- Frame format, 7 bytes: SYNC, ADDR, D3 (MSB), D2, D1, D0, CSUM.
- Checksum rule: CSUM = (ADDR + D3 + D2 + D1 + D0) mod 256.
- FSM states: IDLE, ADDR, D3, D2, D1, D0, CSUM, COMMIT, ERROR.
  - IDLE: byte == SYNC_BYTE → ADDR; any other byte is silently discarded.
  - ADDR → D3 → D2 → D1 → D0 → CSUM: advance one state per accepted byte. Data bytes shift into a 32-bit register; the 8-bit sum accumulates in parallel.
  - SYNC_BYTE inside a frame is treated as data; there is no mid-frame resync.
  - CSUM byte accepted → COMMIT if checksum matches and ADDR[7:3] == 0; otherwise → ERROR.
  - COMMIT (exactly 1 cycle) → IDLE.
  - ERROR (exactly 1 cycle) → IDLE.
- rx_ready: 1 in IDLE through CSUM; 0 in COMMIT and ERROR. Back-to-back frames therefore lose exactly one cycle.
- COMMIT cycle outputs: wr_en=1, frame_ok=1, param_addr=ADDR[2:0], param_data={D3,D2,D1,D0}.
- ERROR cycle outputs: frame_err=1, wr_en=0. param_addr/param_data unchanged.
- Latency: wr_en is high in the cycle after the CSUM byte is accepted.
- param_addr/param_data are registered and hold the last committed values between writes.
- wr_en, frame_ok and frame_err are registered pulses, never high for two consecutive cycles.
- busy = (state != IDLE).
- Reset values: rx_ready=1, wr_en=0, frame_ok=0, frame_err=0, busy=0, param_addr=0, param_data=0, state=IDLE, accumulators=0.
- Reset mid-frame: partial frame discarded, no write issued.
- rx_valid held high while rx_ready=0: the byte is not consumed and is accepted on the next ready cycle.

Optional Feature:
- Macro: CAM_PARAM_TIMEOUT_EN
- Defined:
  - A counter runs in states ADDR..CSUM, clears on each accepted byte and on entry to ADDR.
  - When the count reaches TIMEOUT_CYCLES-1 with no byte accepted → ERROR (frame_err pulse) → IDLE.
  - Timeout and byte acceptance in the same cycle: the byte wins.
- Undefined: no counter; the FSM waits indefinitely for the next byte.

Decomposition:
- Package cam_param_pkg holds:
  - state enum;
  - CAM_PARAM_SYNC default 8'hA5;
  - CAM_PARAM_FRAME_LEN = 7;
  - CAM_PARAM_ADDR_W = 3;
  - CAM_PARAM_DATA_W = 32.
  These constants are shared with the parameter store.
- No sub-module required; the checksum accumulator and shifter are inline.

Test Plan:
- Send A5 02 00 00 02 80 84 → one cycle later wr_en=1, frame_ok=1, param_addr=2, param_data=0x00000280; frame_err never asserts.
- Send 3C 11 A5 04 FF FF FC 18 16 → leading bytes ignored; wr_en with param_addr=4, param_data=0xFFFFFC18.
- Send A5 01 00 00 00 05 07 (bad checksum, correct value is 06) → frame_err one pulse, no wr_en, param_addr/param_data unchanged.
- Send A5 09 00 00 00 01 0A (checksum correct, address out of range) → frame_err, no write.
- Two valid frames with rx_valid held high continuously → two wr_en pulses 8 cycles apart; rx_ready low exactly during each COMMIT.
- Assert rst_n low after A5 03 00 → all outputs return to reset values; a following full valid frame commits normally. With CAM_PARAM_TIMEOUT_EN and TIMEOUT_CYCLES=16: stall after A5 03 → frame_err 16 cycles after the last accepted byte, then IDLE.
